// File: rtl/dm_line_cache_if.sv
// rtl/dm_line_cache_if.sv - request/response channel bundle for dm_line_cache
//
// Groups the cache's request and response valid/ready channels.
//   req_val/req_rdy/req_rw/req_addr/req_wdata : request channel (master -> cache)
//   resp_val/resp_rdy/resp_hit/resp_rdata     : response channel (cache -> master)
// Modports: master (requester side), slave (cache side).

interface dm_line_cache_if #(
    parameter int ADDR_WIDTH = 52,
    parameter int DATA_WIDTH = 512
);
    logic                  req_val;
    logic                  req_rdy;
    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_val;
    logic                  resp_rdy;
    logic                  resp_hit;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_val, req_rw, req_addr, req_wdata, resp_rdy,
        input  req_rdy, resp_val, resp_hit, resp_rdata
    );

    modport slave (
        input  req_val, req_rw, req_addr, req_wdata, resp_rdy,
        output req_rdy, resp_val, resp_hit, resp_rdata
    );
endinterface

// File: rtl/dm_line_cache.sv
// rtl/dm_line_cache.sv - direct-mapped write-allocate line cache with flush and hit/miss counters
//
// Ports:
//   clk        : clock
//   rst        : synchronous, active-low reset
//   bus        : dm_line_cache_if.slave request/response channels
//   flush      : invalidate-all request, sampled only while idle (wins over a request)
//   flush_done : one-cycle pulse in the last flush cycle
//   hit_cnt    : saturating lookup hit count
//   miss_cnt   : saturating lookup miss count
//
// Flow: IDLE accepts a request -> LOOKUP (tag check, write, counters) -> RESP
// (held until resp_rdy) -> IDLE. A flush walks every line, one per cycle.
// HALF_ACCESS=1 splits each line into two halves with their own valid bits;
// the half is selected by the top offset bit and carried in the low data bits.

module dm_line_cache #(
    parameter int ADDR_WIDTH      = 52,
    parameter int DATA_WIDTH      = 512,
    parameter int NUM_LINES       = 4,
    parameter int CACHE_LINE_SIZE = 64,
    parameter int HALF_ACCESS     = 0,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dm_line_cache_if.slave       bus,
    input  logic                 flush,
    output logic                 flush_done,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);
    localparam int OFF_W = $clog2(CACHE_LINE_SIZE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int HW    = DATA_WIDTH / 2;

    localparam logic [DATA_WIDTH-1:0] DEAD_PATTERN = {(DATA_WIDTH/16){16'hdead}};
    localparam logic [IDX_W-1:0]      LAST_IDX     = IDX_W'(NUM_LINES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t state;
    state_t state_n;

    // Latched request
    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Line storage; only the valid bits are reset
    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];
    logic [NUM_LINES-1:0]  line_valid;
    logic [NUM_LINES-1:0]  hv_lo;
    logic [NUM_LINES-1:0]  hv_hi;

    logic [IDX_W-1:0]      flush_idx;

    logic                  resp_hit_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    // FSM strobes
    logic do_accept;
    logic do_lookup;
    logic do_flush_clr;

    // Lookup decode
    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_half;
    logic                  tag_match;
    logic                  lk_hit;
    logic [DATA_WIDTH-1:0] cur_line;
    logic [HW-1:0]         sel_half;
    logic [HW-1:0]         wr_lo;
    logic [HW-1:0]         wr_hi;
    logic [DATA_WIDTH-1:0] rd_line;
    logic [DATA_WIDTH-1:0] wr_line;
    logic [DATA_WIDTH-1:0] lk_rdata;

    // Offset bits below the half select never affect a lookup
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr_q[OFF_W-2:0];

    // ------------------------------------------------------------------
    // Lookup datapath, evaluated from the latched request
    // ------------------------------------------------------------------
    always_comb begin
        lk_idx    = addr_q[OFF_W+IDX_W-1:OFF_W];
        lk_tag    = addr_q[ADDR_WIDTH-1:OFF_W+IDX_W];
        lk_half   = addr_q[OFF_W-1];
        cur_line  = data_mem[lk_idx];
        tag_match = line_valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
        // In full-line mode both half-valid bits are always written together,
        // so the half check reduces to the line valid bit there.
        lk_hit    = tag_match && (lk_half ? hv_hi[lk_idx] : hv_lo[lk_idx]);
        sel_half  = lk_half ? cur_line[DATA_WIDTH-1:HW] : cur_line[HW-1:0];

        if (HALF_ACCESS != 0) begin
            rd_line = {{HW{1'b0}}, sel_half};
            // The untouched half survives only when the line already holds this tag
            wr_lo   = lk_half ? (tag_match ? cur_line[HW-1:0] : '0) : wdata_q[HW-1:0];
            wr_hi   = lk_half ? wdata_q[HW-1:0] : (tag_match ? cur_line[DATA_WIDTH-1:HW] : '0);
        end else begin
            rd_line = cur_line;
            wr_lo   = wdata_q[HW-1:0];
            wr_hi   = wdata_q[DATA_WIDTH-1:HW];
        end
        wr_line = {wr_hi, wr_lo};

        if (!rw_q) begin
            lk_rdata = '0;
        end else if (lk_hit) begin
            lk_rdata = rd_line;
        end else begin
            lk_rdata = DEAD_PATTERN;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        bus.req_rdy  = 1'b0;
        bus.resp_val = 1'b0;
        flush_done   = 1'b0;
        do_accept    = 1'b0;
        do_lookup    = 1'b0;
        do_flush_clr = 1'b0;

        case (state)
            S_IDLE: begin
                bus.req_rdy = !flush;
                if (flush) begin
                    state_n = S_FLUSH;
                end else if (bus.req_val) begin
                    do_accept = 1'b1;
                    state_n   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                do_lookup = 1'b1;
                state_n   = S_RESP;
            end
            S_RESP: begin
                bus.resp_val = 1'b1;
                if (bus.resp_rdy) begin
                    state_n = S_IDLE;
                end
            end
            S_FLUSH: begin
                do_flush_clr = 1'b1;
                if (flush_idx == LAST_IDX) begin
                    flush_done = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Reset-bearing control state: valid bits, counters, response regs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_valid   <= '0;
            hv_lo        <= '0;
            hv_hi        <= '0;
            flush_idx    <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            if (do_flush_clr) begin
                line_valid[flush_idx] <= 1'b0;
                hv_lo[flush_idx]      <= 1'b0;
                hv_hi[flush_idx]      <= 1'b0;
                // Wraps back to zero after the last line (NUM_LINES is a power of 2)
                flush_idx             <= flush_idx + IDX_W'(1);
            end

            if (do_lookup) begin
                resp_hit_q   <= lk_hit;
                resp_rdata_q <= lk_rdata;

                if (lk_hit) begin
                    if (hit_cnt != '1) begin
                        hit_cnt <= hit_cnt + CNT_ONE;
                    end
                end else begin
                    if (miss_cnt != '1) begin
                        miss_cnt <= miss_cnt + CNT_ONE;
                    end
                end

                if (!rw_q) begin
                    line_valid[lk_idx] <= 1'b1;
                    if (HALF_ACCESS != 0) begin
                        if (lk_half) begin
                            hv_hi[lk_idx] <= 1'b1;
                            if (!tag_match) begin
                                hv_lo[lk_idx] <= 1'b0;
                            end
                        end else begin
                            hv_lo[lk_idx] <= 1'b1;
                            if (!tag_match) begin
                                hv_hi[lk_idx] <= 1'b0;
                            end
                        end
                    end else begin
                        hv_lo[lk_idx] <= 1'b1;
                        hv_hi[lk_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Non-reset storage: request latch and tag/data arrays.
    // The array write is gated by rst so a reset during LOOKUP leaves no trace.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_accept) begin
            rw_q    <= bus.req_rw;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
        if (rst && do_lookup && !rw_q) begin
            tag_mem[lk_idx]  <= lk_tag;
            data_mem[lk_idx] <= wr_line;
        end
    end

    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule
